// File: rtl/nn_cfg_pkg.sv
// Network shape and shared types for weight loading.
// Per-layer sizes drive the load sequencer counters.
package nn_cfg_pkg;

  localparam int NUM_LAYERS = 2;
  localparam int WEIGHT_WORD_BITS = 32;

  localparam int LAYER_NEURONS [NUM_LAYERS] = '{2, 3};
  localparam int LAYER_WEIGHTS [NUM_LAYERS] = '{4, 2};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } seq_state_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit cfg_ok(
    input int nl,
    input int mn,
    input int mw
  );
    bit ok;
    ok = (nl >= 1) && (nl <= NUM_LAYERS);
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (i < nl) begin
        if (LAYER_NEURONS[i] < 1) ok = 1'b0;
        if (LAYER_WEIGHTS[i] < 1) ok = 1'b0;
        if (LAYER_NEURONS[i] > mn) ok = 1'b0;
        if (LAYER_WEIGHTS[i] > mw) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/weight_load_sequencer_if.sv
// Upstream weight stream plus the broadcast
// bus seen by every weight_memory_control.
interface weight_load_sequencer_if;
  import nn_cfg_pkg::*;

  logic                        s_weight_valid;
  logic                        s_weight_ready;
  logic [WEIGHT_WORD_BITS-1:0] s_weight_data;
  logic                        weight_valid;
  logic [WEIGHT_WORD_BITS-1:0] weight_value;
  logic [31:0]                 config_layer_no;
  logic [31:0]                 config_neuron_no;

  modport slave (
    input  s_weight_valid,
    input  s_weight_data,
    output s_weight_ready,
    output weight_valid,
    output weight_value,
    output config_layer_no,
    output config_neuron_no
  );

  modport master (
    output s_weight_valid,
    output s_weight_data,
    input  s_weight_ready,
    input  weight_valid,
    input  weight_value,
    input  config_layer_no,
    input  config_neuron_no
  );

endinterface

// File: rtl/layer_neuron_counter.sv
// Nested weight/neuron/layer position counters.
// last_word flags the final word of the last layer.
module layer_neuron_counter
  import nn_cfg_pkg::*;
#(
  parameter int NL = NUM_LAYERS,
  parameter int WW = 10,
  parameter int NW = 5,
  parameter int LW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic          clear,
  output logic [NW-1:0] n_cnt,
  output logic [LW-1:0] l_cnt,
  output logic          last_word
);

  logic [WW-1:0] w_cnt;
  logic          w_last;
  logic          n_last;
  logic          l_last;

  assign w_last =
    w_cnt == WW'(LAYER_WEIGHTS[l_cnt] - 1);
  assign n_last =
    n_cnt == NW'(LAYER_NEURONS[l_cnt] - 1);
  assign l_last = l_cnt == LW'(NL - 1);
  assign last_word = w_last & n_last & l_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_cnt <= '0;
      n_cnt <= '0;
      l_cnt <= '0;
    end else if (clear) begin
      w_cnt <= '0;
      n_cnt <= '0;
      l_cnt <= '0;
    end else if (advance) begin
      if (w_last) begin
        w_cnt <= '0;
        if (n_last) begin
          n_cnt <= '0;
          l_cnt <= l_last ? '0 : l_cnt + 1'b1;
        end else begin
          n_cnt <= n_cnt + 1'b1;
        end
      end else begin
        w_cnt <= w_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_load_sequencer.sv
// Streams layer-major weight words onto the
// shared weight-memory broadcast bus.
module weight_load_sequencer
  import nn_cfg_pkg::*;
#(
  parameter int num_layers  = NUM_LAYERS,
  parameter int max_neurons = 30,
  parameter int max_weights = 784
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  weight_load_sequencer_if.slave bus
);

  localparam int WW = cw(max_weights);
  localparam int NW = cw(max_neurons);
  localparam int LW = cw(num_layers);

  if (!cfg_ok(num_layers, max_neurons,
              max_weights)) begin : g_cfg_bad
    $fatal(1, "weight_load_sequencer: bad cfg");
  end

  seq_state_t  state;
  logic        ready;
  logic        accept;
  logic        clear;
  logic        last_word;
  logic [NW-1:0] n_cnt;
  logic [LW-1:0] l_cnt;

  logic        wv_q;
  logic [WEIGHT_WORD_BITS-1:0] val_q;
  logic [31:0] layer_q;
  logic [31:0] neuron_q;

  assign ready  = (state == LOAD) & ~abort;
  assign accept = bus.s_weight_valid & ready;
  assign clear  = ((state == LOAD) & abort)
                | ((state == IDLE) & start);

  layer_neuron_counter #(
    .NL(num_layers),
    .WW(WW),
    .NW(NW),
    .LW(LW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .advance  (accept),
    .clear    (clear),
    .n_cnt    (n_cnt),
    .l_cnt    (l_cnt),
    .last_word(last_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wv_q     <= 1'b0;
      val_q    <= '0;
      layer_q  <= '0;
      neuron_q <= '0;
    end else begin
      wv_q <= accept;
      done <= 1'b0;
      if (accept) begin
        val_q    <= bus.s_weight_data;
        layer_q  <= 32'(l_cnt);
        neuron_q <= 32'(n_cnt);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (accept && last_word) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          // done lands the cycle after the last broadcast
          state <= IDLE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_weight_ready   = ready;
  assign bus.weight_valid     = wv_q;
  assign bus.weight_value     = val_q;
  assign bus.config_layer_no  = layer_q;
  assign bus.config_neuron_no = neuron_q;

endmodule
